// File: rtl/rom_decoder_pkg.sv
// rom_decoder_pkg: control-ROM code map, RV32 opcode/funct7 constants, decode-stage state
// and the deferred branch-resolution helper shared by the decode pipe.
package rom_decoder_pkg;
    localparam logic [5:0] CODE_ADD = 6'd0, CODE_SUB = 6'd1, CODE_SLL = 6'd2, CODE_SLT = 6'd3,
        CODE_SLTU = 6'd4, CODE_XOR = 6'd5, CODE_SRL = 6'd6, CODE_SRA = 6'd7, CODE_OR = 6'd8,
        CODE_AND = 6'd9, CODE_ADDI = 6'd10, CODE_SLTI = 6'd11, CODE_SLTIU = 6'd12,
        CODE_XORI = 6'd13, CODE_ORI = 6'd14, CODE_ANDI = 6'd15, CODE_SLLI = 6'd16,
        CODE_SRLI = 6'd17, CODE_SRAI = 6'd18, CODE_LB = 6'd19, CODE_LH = 6'd20, CODE_LW = 6'd21,
        CODE_LBU = 6'd22, CODE_LHU = 6'd23, CODE_SB = 6'd24, CODE_SH = 6'd25, CODE_SW = 6'd26,
        CODE_BEQ_T = 6'd27, CODE_BEQ_F = 6'd28, CODE_BNE_T = 6'd29, CODE_BNE_F = 6'd30,
        CODE_BLT_T = 6'd31, CODE_BLT_F = 6'd32, CODE_BGE_T = 6'd33, CODE_BGE_F = 6'd34,
        CODE_BLTU_T = 6'd35, CODE_BLTU_F = 6'd36, CODE_BGEU_T = 6'd37, CODE_BGEU_F = 6'd38,
        CODE_LUI = 6'd39, CODE_AUIPC = 6'd40, CODE_JAL = 6'd41, CODE_JALR = 6'd42,
        CODE_MUL = 6'd43, CODE_MULH = 6'd44, CODE_MULHSU = 6'd45, CODE_MULHU = 6'd46,
        CODE_DIV = 6'd47, CODE_DIVU = 6'd48, CODE_REM = 6'd49, CODE_REMU = 6'd50,
        CODE_ILLEGAL = 6'd63;
    localparam logic [6:0] OPC_OP = 7'b0110011, OPC_OP_IMM = 7'b0010011, OPC_LOAD = 7'b0000011,
        OPC_STORE = 7'b0100011, OPC_BRANCH = 7'b1100011, OPC_LUI = 7'b0110111,
        OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111, OPC_JALR = 7'b1100111;
    localparam logic [6:0] F7_BASE = 7'b0000000, F7_ALT = 7'b0100000, F7_MULDIV = 7'b0000001;
    typedef enum logic [1:0] {D_EMPTY, D_FULL, D_WAIT_BR} dstate_e;
    // Each branch owns a taken/not-taken code pair; the lower code means the condition held.
    function automatic logic [5:0] br_code(input logic [2:0] f3, input logic eq, input logic lt);
        logic [5:0] pair;
        pair = f3[2] ? {4'd0, f3[1:0]} + 6'd2 : {5'd0, f3[0]};
        return CODE_BEQ_T + (pair << 1) + {5'd0, ~(f3[2] ? lt : eq)};
    endfunction
endpackage

// File: rtl/rom_decoder_pipe_if.sv
// rom_decoder_pipe_if: fetch handshake, comparator flags, flush and output handshake of the decode pipe.
interface rom_decoder_pipe_if #(
    parameter int WIDTH_INST_LENGTH = 32,
    parameter int WIDTH_DATAOUT_LENGTH = 6
);
    logic InstValid, InstReady, BrValid, BrEq, BrLT, Flush, OutValid, OutReady, Illegal;
    logic [WIDTH_INST_LENGTH-1:0] Inst;
    logic [WIDTH_DATAOUT_LENGTH-1:0] DataOut;
    modport master (
        output InstValid, Inst, BrValid, BrEq, BrLT, Flush, OutReady,
        input InstReady, OutValid, DataOut, Illegal
    );
    modport slave (
        input InstValid, Inst, BrValid, BrEq, BrLT, Flush, OutReady,
        output InstReady, OutValid, DataOut, Illegal
    );
endinterface

// File: rtl/rom_decoder_comb.sv
// rom_decoder_comb: combinational RV32I(+M) decode into base code, branch flag and illegal flag.
module rom_decoder_comb
    import rom_decoder_pkg::*;
#(
    parameter int WIDTH_INST_LENGTH = 32,
    parameter bit EN_M_EXT = 1'b1
) (
    input  logic [WIDTH_INST_LENGTH-1:0] inst_i,
    output logic [5:0]                   code_o,
    output logic                         is_branch_o,
    output logic                         illegal_o
);
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic unused_fields;
    assign opc = inst_i[6:0];
    assign f3 = inst_i[14:12];
    assign f7 = inst_i[31:25];
    assign unused_fields = ^{inst_i[24:15], inst_i[11:7]};
    // Opcodes carry Inst[1:0], so a non-32-bit quadrant never matches and falls to illegal.
    always_comb begin
        code_o = CODE_ILLEGAL;
        is_branch_o = 1'b0;
        case (opc)
            OPC_OP: case (f7)
                F7_BASE: case (f3)
                    3'd0: code_o = CODE_ADD;
                    3'd1: code_o = CODE_SLL;
                    3'd2: code_o = CODE_SLT;
                    3'd3: code_o = CODE_SLTU;
                    3'd4: code_o = CODE_XOR;
                    3'd5: code_o = CODE_SRL;
                    3'd6: code_o = CODE_OR;
                    default: code_o = CODE_AND;
                endcase
                F7_ALT: code_o = f3 == 3'd0 ? CODE_SUB : f3 == 3'd5 ? CODE_SRA : CODE_ILLEGAL;
                F7_MULDIV: code_o = EN_M_EXT ? CODE_MUL + {3'd0, f3} : CODE_ILLEGAL;
                default: ;
            endcase
            OPC_OP_IMM: case (f3)
                3'd0: code_o = CODE_ADDI;
                3'd1: code_o = f7 == F7_BASE ? CODE_SLLI : CODE_ILLEGAL;
                3'd2: code_o = CODE_SLTI;
                3'd3: code_o = CODE_SLTIU;
                3'd4: code_o = CODE_XORI;
                3'd5: code_o = f7 == F7_BASE ? CODE_SRLI : f7 == F7_ALT ? CODE_SRAI : CODE_ILLEGAL;
                3'd6: code_o = CODE_ORI;
                default: code_o = CODE_ANDI;
            endcase
            OPC_LOAD: case (f3)
                3'd0: code_o = CODE_LB;
                3'd1: code_o = CODE_LH;
                3'd2: code_o = CODE_LW;
                3'd4: code_o = CODE_LBU;
                3'd5: code_o = CODE_LHU;
                default: ;
            endcase
            OPC_STORE: case (f3)
                3'd0: code_o = CODE_SB;
                3'd1: code_o = CODE_SH;
                3'd2: code_o = CODE_SW;
                default: ;
            endcase
            OPC_BRANCH: begin
                is_branch_o = f3[2:1] != 2'b01;
                code_o = is_branch_o ? CODE_BEQ_T : CODE_ILLEGAL;
            end
            OPC_LUI: code_o = CODE_LUI;
            OPC_AUIPC: code_o = CODE_AUIPC;
            OPC_JAL: code_o = CODE_JAL;
            OPC_JALR: code_o = f3 == 3'd0 ? CODE_JALR : CODE_ILLEGAL;
            default: ;
        endcase
    end
    assign illegal_o = code_o == CODE_ILLEGAL;
endmodule

// File: rtl/rom_decoder_pipe.sv
// rom_decoder_pipe: two-stage flow-controlled decoder; D holds the decoded entry until its
// branch flags arrive, O holds the control-ROM address for the consumer.
module rom_decoder_pipe
    import rom_decoder_pkg::*;
#(
    parameter int WIDTH_INST_LENGTH = 32,
    parameter int WIDTH_DATAOUT_LENGTH = 6,
    parameter bit EN_M_EXT = 1'b1
) (
    input logic clk,
    input logic rst_n,
    rom_decoder_pipe_if.slave bus
);
    dstate_e state_q, state_d;
    logic [5:0] code_q, dec_code;
    logic [2:0] f3_q;
    logic br_q, ill_q, dec_br, dec_ill, d_full, o_accept, xfer, accept, load_o;
    logic out_valid_q, out_valid_d, illegal_q, illegal_d;
    logic [WIDTH_DATAOUT_LENGTH-1:0] data_q, data_d, res_code;
    rom_decoder_comb #(.WIDTH_INST_LENGTH(WIDTH_INST_LENGTH), .EN_M_EXT(EN_M_EXT)) u_comb (
        .inst_i(bus.Inst), .code_o(dec_code), .is_branch_o(dec_br), .illegal_o(dec_ill)
    );
    assign d_full = state_q != D_EMPTY;
    assign o_accept = !out_valid_q || bus.OutReady;
    assign xfer = d_full && o_accept && (!br_q || bus.BrValid);
    assign bus.InstReady = !d_full || xfer;
    assign accept = bus.InstValid && bus.InstReady && !bus.Flush;
    assign load_o = xfer && !bus.Flush;
    assign res_code = br_q ? br_code(f3_q, bus.BrEq, bus.BrLT) : code_q;
    always_comb begin
        state_d = state_q;
        if (bus.Flush) state_d = D_EMPTY;
        else if (accept) state_d = D_FULL;
        else if (xfer) state_d = D_EMPTY;
        else if (d_full && br_q && !bus.BrValid) state_d = D_WAIT_BR;
        out_valid_d = bus.Flush ? 1'b0 : xfer ? 1'b1 : o_accept ? 1'b0 : out_valid_q;
        data_d = load_o ? res_code : data_q;
        illegal_d = load_o ? ill_q : illegal_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= D_EMPTY;
            code_q <= '0;
            f3_q <= '0;
            br_q <= 1'b0;
            ill_q <= 1'b0;
            out_valid_q <= 1'b0;
            data_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            out_valid_q <= out_valid_d;
            data_q <= data_d;
            illegal_q <= illegal_d;
            if (accept) begin
                code_q <= dec_code;
                f3_q <= bus.Inst[14:12];
                br_q <= dec_br;
                ill_q <= dec_ill;
            end
        end
    end
    assign bus.OutValid = out_valid_q;
    assign bus.DataOut = data_q;
    assign bus.Illegal = illegal_q;
endmodule

// File: tb/tb_rom_decoder_pipe.sv
// tb_rom_decoder_pipe: directed pipeline scenarios plus randomized streams scored against a
// pattern-table instruction model, for EN_M_EXT=1 and EN_M_EXT=0 instances side by side.
module tb_rom_decoder_pipe;
    logic clk = 1'b0, rst_n = 1'b0;
    int checks = 0, errors = 0;
    always #5 clk = ~clk;
    rom_decoder_pipe_if bus();
    rom_decoder_pipe_if bus0();
    rom_decoder_pipe #(.EN_M_EXT(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    rom_decoder_pipe #(.EN_M_EXT(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    assign bus0.InstValid = bus.InstValid;
    assign bus0.Inst = bus.Inst;
    assign bus0.BrValid = bus.BrValid;
    assign bus0.BrEq = bus.BrEq;
    assign bus0.BrLT = bus.BrLT;
    assign bus0.Flush = bus.Flush;
    assign bus0.OutReady = bus.OutReady;

    typedef struct packed {logic [31:0] mask; logic [31:0] match; logic [5:0] code;} pat_t;
    localparam logic [31:0] M_R = 32'hFE00707F, M_I = 32'h0000707F, M_U = 32'h0000007F;
    pat_t pats[$];
    int row[8];
    logic [6:0] opcs[9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};
    logic [6:0] f7s[3] = '{7'h00, 7'h20, 7'h01};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic add(input logic [31:0] mask, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [6:0] op, input int code);
        pats.push_back('{mask, {f7, 10'd0, f3, 5'd0, op}, code[5:0]});
    endtask

    task automatic add_row(input logic [31:0] mask, input logic [6:0] f7, input logic [6:0] op);
        for (int k = 0; k < 8; k++) if (row[k] >= 0) add(mask, f7, k[2:0], op, row[k]);
    endtask

    task automatic build();
        row = '{0, 2, 3, 4, 5, 6, 8, 9};          add_row(M_R, 7'h00, 7'h33);
        row = '{43, 44, 45, 46, 47, 48, 49, 50};  add_row(M_R, 7'h01, 7'h33);
        add(M_R, 7'h20, 3'd0, 7'h33, 1);
        add(M_R, 7'h20, 3'd5, 7'h33, 7);
        row = '{10, -1, 11, 12, 13, -1, 14, 15};  add_row(M_I, 7'h00, 7'h13);
        add(M_R, 7'h00, 3'd1, 7'h13, 16);
        add(M_R, 7'h00, 3'd5, 7'h13, 17);
        add(M_R, 7'h20, 3'd5, 7'h13, 18);
        row = '{19, 20, 21, -1, 22, 23, -1, -1};  add_row(M_I, 7'h00, 7'h03);
        row = '{24, 25, 26, -1, -1, -1, -1, -1};  add_row(M_I, 7'h00, 7'h23);
        row = '{27, 29, -1, -1, 31, 33, 35, 37};  add_row(M_I, 7'h00, 7'h63);
        add(M_U, 7'h00, 3'd0, 7'h37, 39);
        add(M_U, 7'h00, 3'd0, 7'h17, 40);
        add(M_U, 7'h00, 3'd0, 7'h6F, 41);
        add(M_I, 7'h00, 3'd0, 7'h67, 42);
    endtask

    // Table lookup, then branch codes step to the not-taken partner when the condition fails.
    function automatic logic [5:0] ref_out(input logic [31:0] inst, input bit m_en,
                                           input logic eq, input logic lt);
        int c;
        c = 63;
        foreach (pats[k])
            if (c == 63 && (inst & pats[k].mask) == pats[k].match &&
                (m_en || pats[k].code < 43 || pats[k].code > 50)) c = int'(pats[k].code);
        if (c >= 27 && c <= 38) c += ((c <= 29 ? eq : lt) ? 0 : 1);
        return c[5:0];
    endfunction

    function automatic logic [31:0] rnd_inst();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(7) == 0) return r;
        return {($urandom_range(3) == 0 ? r[31:25] : f7s[$urandom_range(2)]), r[24:7],
                opcs[$urandom_range(8)]};
    endfunction

    task automatic beq_case(input logic eq, input logic [5:0] exp);
        @(negedge clk); bus.InstValid = 1; bus.Inst = 32'h00208463; bus.BrValid = 0; bus.BrEq = eq;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); bus.InstValid = 0;
            #1 chk("beq_wait_ready", bus.InstReady, 0);
            chk("beq_wait_ov", bus.OutValid, 0);
        end
        @(negedge clk); bus.BrValid = 1;
        #1 chk("beq_ready", bus.InstReady, 1);
        @(negedge clk); bus.BrValid = 0;
        #1 chk("beq_code", bus.DataOut, exp);
        chk("beq_ov", bus.OutValid, 1);
    endtask

    task automatic random_phase(input logic eq, input logic lt, input int n);
        logic [5:0] q1[$], q0[$];
        bus.BrValid = 1; bus.BrEq = eq; bus.BrLT = lt; bus.Flush = 0;
        for (int i = 0; i < n + 40; i++) begin
            @(negedge clk);
            bus.InstValid = i < n && $urandom_range(3) != 0;
            bus.Inst = rnd_inst();
            bus.OutReady = i >= n || $urandom_range(3) != 0;
            #1;
            if (bus.OutValid && bus.OutReady) begin
                chk("rnd_expected_pending", q1.size() != 0, 1);
                if (q1.size() != 0) begin
                    chk("rnd_code_m1", bus.DataOut, q1[0]);
                    chk("rnd_ill_m1", bus.Illegal, q1[0] == 6'd63);
                    chk("rnd_code_m0", bus0.DataOut, q0[0]);
                    chk("rnd_ill_m0", bus0.Illegal, q0[0] == 6'd63);
                    void'(q1.pop_front());
                    void'(q0.pop_front());
                end
            end
            if (bus.InstValid && bus.InstReady) begin
                q1.push_back(ref_out(bus.Inst, 1'b1, eq, lt));
                q0.push_back(ref_out(bus.Inst, 1'b0, eq, lt));
            end
        end
        chk("rnd_all_drained", q1.size(), 0);
    endtask

    initial begin
        bus.InstValid = 0; bus.Inst = 0; bus.BrValid = 0; bus.BrEq = 0; bus.BrLT = 0;
        bus.Flush = 0; bus.OutReady = 1;
        build();
        repeat (2) @(negedge clk);
        #1 chk("rst_ov", bus.OutValid, 0);
        chk("rst_dataout", bus.DataOut, 0);
        chk("rst_illegal", bus.Illegal, 0);
        chk("rst_ready", bus.InstReady, 1);
        rst_n = 1;
        // ADD then SUB back to back
        @(negedge clk); bus.InstValid = 1; bus.Inst = 32'h003100B3;
        @(negedge clk); bus.Inst = 32'h403100B3;
        #1 chk("add_in_d_ov", bus.OutValid, 0);
        chk("sub_ready", bus.InstReady, 1);
        @(negedge clk); bus.InstValid = 0;
        #1 chk("add_ov", bus.OutValid, 1);
        chk("add_code", bus.DataOut, 0);
        @(negedge clk);
        #1 chk("sub_ov", bus.OutValid, 1);
        chk("sub_code", bus.DataOut, 1);
        @(negedge clk);
        #1 chk("idle_ov", bus.OutValid, 0);
        // MUL with and without the M extension
        @(negedge clk); bus.InstValid = 1; bus.Inst = 32'h023100B3;
        @(negedge clk); bus.InstValid = 0;
        @(negedge clk);
        #1 chk("mul_code_m1", bus.DataOut, 43);
        chk("mul_ill_m1", bus.Illegal, 0);
        chk("mul_code_m0", bus0.DataOut, 63);
        chk("mul_ill_m0", bus0.Illegal, 1);
        beq_case(1'b1, 6'd27);
        beq_case(1'b0, 6'd28);
        // Output stall with ADDI, XORI, ORI streaming
        @(negedge clk); bus.OutReady = 0; bus.InstValid = 1; bus.Inst = 32'h00000093;
        @(negedge clk); bus.Inst = 32'h00004093;
        #1 chk("stall_xori_ready", bus.InstReady, 1);
        @(negedge clk); bus.Inst = 32'h00006093;
        #1 chk("stall_ready0", bus.InstReady, 0);
        chk("stall_code0", bus.DataOut, 10);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1 chk("stall_ready", bus.InstReady, 0);
            chk("stall_hold", bus.DataOut, 10);
            chk("stall_ov", bus.OutValid, 1);
        end
        @(negedge clk); bus.OutReady = 1;
        #1 chk("release_ready", bus.InstReady, 1);
        @(negedge clk); bus.InstValid = 0;
        #1 chk("release_xori", bus.DataOut, 13);
        chk("release_ov1", bus.OutValid, 1);
        @(negedge clk);
        #1 chk("release_ori", bus.DataOut, 14);
        chk("release_ov2", bus.OutValid, 1);
        // Flush with a waiting branch and a full output stage
        @(negedge clk); bus.OutReady = 0; bus.InstValid = 1; bus.Inst = 32'h003100B3;
        @(negedge clk); bus.Inst = 32'h00208463;
        @(negedge clk); bus.Inst = 32'h00000093; bus.BrValid = 0;
        #1 chk("flush_pre_ready", bus.InstReady, 0);
        @(negedge clk); bus.Flush = 1; bus.OutReady = 1; bus.BrValid = 1; bus.BrEq = 1;
        bus.Inst = 32'h00006093;
        #1 chk("flush_pre_ov", bus.OutValid, 1);
        @(negedge clk); bus.Flush = 0; bus.InstValid = 0; bus.BrValid = 0;
        #1 chk("flush_ov", bus.OutValid, 0);
        chk("flush_empty_ready", bus.InstReady, 1);
        @(negedge clk);
        #1 chk("flush_dropped", bus.OutValid, 0);
        // Illegal all-zero word held in O, then asynchronous reset mid-stream
        @(negedge clk); bus.OutReady = 0; bus.InstValid = 1; bus.Inst = 32'h00000000;
        @(negedge clk); bus.Inst = 32'h403100B3;
        @(negedge clk); bus.InstValid = 0;
        #1 chk("zero_code_m1", bus.DataOut, 63);
        chk("zero_ill_m1", bus.Illegal, 1);
        chk("zero_code_m0", bus0.DataOut, 63);
        chk("zero_ill_m0", bus0.Illegal, 1);
        #1 rst_n = 0;
        #1 chk("arst_ov", bus.OutValid, 0);
        chk("arst_dataout", bus.DataOut, 0);
        chk("arst_illegal", bus.Illegal, 0);
        chk("arst_ready", bus.InstReady, 1);
        #1 rst_n = 1; bus.OutReady = 1;
        @(negedge clk);
        #1 chk("arst_d_discarded", bus.OutValid, 0);
        random_phase(1'b0, 1'b1, 300);
        random_phase(1'b1, 1'b0, 300);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
